// File: rtl/mark_history_tracker.sv
// Live-mark tracker for two players on a CELLS-cell board. Each player keeps at most
// HIST marks in a circular history; placing one more mark retires that player's oldest.
module mark_history_tracker #(
  parameter int CELLS        = 9,
  parameter int POS_W        = 4,
  parameter int HIST         = 3,
  parameter int ENFORCE_TURN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         game_state,
  input  logic                         clear,
  input  logic                         player_a_move,
  input  logic                         player_b_move,
  input  logic [POS_W-1:0]             pos,
  output logic [2*CELLS-1:0]           game_grid,
  output logic                         move_ack,
  output logic                         move_reject,
  output logic [1:0]                   reject_code,
  output logic [$clog2(HIST+1)-1:0]    a_count,
  output logic [$clog2(HIST+1)-1:0]    b_count,
  output logic                         oldest_valid,
  output logic [POS_W-1:0]             oldest_pos,
  output logic                         turn
);

  localparam int CNT_W = $clog2(HIST + 1);
  localparam int PTR_W = (HIST > 1) ? $clog2(HIST) : 1;

  localparam logic [1:0] CODE_OCCUPIED = 2'd1;
  localparam logic [1:0] CODE_RANGE    = 2'd2;
  localparam logic [1:0] CODE_TURN     = 2'd3;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(HIST - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CELLS-1:0] cell_bit(input logic [POS_W-1:0] p);
    return CELLS'(1) << p;
  endfunction

  logic [CELLS-1:0] r_grid_a, r_grid_b;
  logic [POS_W-1:0] r_fifo_a [HIST];
  logic [POS_W-1:0] r_fifo_b [HIST];
  logic [PTR_W-1:0] r_wp_a, r_rp_a, r_wp_b, r_rp_b;
  logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
  logic             r_turn, r_ack, r_rej;
  logic [1:0]       r_code;

  logic [CELLS-1:0] w_sel, w_a_drop, w_b_drop;
  logic             w_a_full, w_b_full, w_both, w_any;
  logic             w_wrong_turn, w_range_err, w_occupied;
  logic             w_oldest_valid;
  logic [POS_W-1:0] w_oldest_pos;

  assign w_sel        = cell_bit(pos);
  assign w_a_full     = (r_cnt_a == CNT_W'(HIST));
  assign w_b_full     = (r_cnt_b == CNT_W'(HIST));
  assign w_a_drop     = w_a_full ? cell_bit(r_fifo_a[r_rp_a]) : '0;
  assign w_b_drop     = w_b_full ? cell_bit(r_fifo_b[r_rp_b]) : '0;
  assign w_both       = player_a_move & player_b_move;
  assign w_any        = player_a_move | player_b_move;
  assign w_wrong_turn = (ENFORCE_TURN != 0) && (player_b_move != r_turn);
  assign w_range_err  = int'(pos) >= CELLS;
  // The mover's own oldest mark still counts as occupied, so it cannot be re-placed.
  assign w_occupied   = |(w_sel & (r_grid_a | r_grid_b));

  always_comb begin
    w_oldest_valid = 1'b0;
    w_oldest_pos   = '0;
    if (!r_turn && w_a_full) begin
      w_oldest_valid = 1'b1;
      w_oldest_pos   = r_fifo_a[r_rp_a];
    end else if (r_turn && w_b_full) begin
      w_oldest_valid = 1'b1;
      w_oldest_pos   = r_fifo_b[r_rp_b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grid_a <= '0;
      r_grid_b <= '0;
      r_wp_a   <= '0;
      r_rp_a   <= '0;
      r_wp_b   <= '0;
      r_rp_b   <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_turn   <= 1'b0;
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      r_code   <= 2'd0;
      for (int i = 0; i < HIST; i++) begin
        r_fifo_a[i] <= '0;
        r_fifo_b[i] <= '0;
      end
    end else if (clear) begin
      r_grid_a <= '0;
      r_grid_b <= '0;
      r_wp_a   <= '0;
      r_rp_a   <= '0;
      r_wp_b   <= '0;
      r_rp_b   <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_turn   <= 1'b0;
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      r_code   <= 2'd0;
      for (int i = 0; i < HIST; i++) begin
        r_fifo_a[i] <= '0;
        r_fifo_b[i] <= '0;
      end
    end else begin
      r_ack <= 1'b0;
      r_rej <= 1'b0;
      if (game_state && w_any) begin
        if (w_both || w_wrong_turn) begin
          r_rej  <= 1'b1;
          r_code <= CODE_TURN;
        end else if (w_range_err) begin
          r_rej  <= 1'b1;
          r_code <= CODE_RANGE;
        end else if (w_occupied) begin
          r_rej  <= 1'b1;
          r_code <= CODE_OCCUPIED;
        end else begin
          r_ack  <= 1'b1;
          r_code <= 2'd0;
          r_turn <= ~r_turn;
          if (player_a_move) begin
            r_grid_a         <= (r_grid_a & ~w_a_drop) | w_sel;
            r_fifo_a[r_wp_a] <= pos;
            r_wp_a           <= ptr_inc(r_wp_a);
            if (w_a_full) r_rp_a <= ptr_inc(r_rp_a);
            else          r_cnt_a <= r_cnt_a + 1'b1;
          end else begin
            r_grid_b         <= (r_grid_b & ~w_b_drop) | w_sel;
            r_fifo_b[r_wp_b] <= pos;
            r_wp_b           <= ptr_inc(r_wp_b);
            if (w_b_full) r_rp_b <= ptr_inc(r_rp_b);
            else          r_cnt_b <= r_cnt_b + 1'b1;
          end
        end
      end
    end
  end

  assign game_grid    = {r_grid_b, r_grid_a};
  assign move_ack     = r_ack;
  assign move_reject  = r_rej;
  assign reject_code  = r_code;
  assign a_count      = r_cnt_a;
  assign b_count      = r_cnt_b;
  assign oldest_valid = w_oldest_valid;
  assign oldest_pos   = w_oldest_pos;
  assign turn         = r_turn;

endmodule

// File: doc/mark_history_tracker.md
Name: mark_history_tracker

Overview:
- Parametrised successor to the fixed 3x3 disappearing-mark recorder.
- Tracks live marks for players A (circle) and B (cross) on a board of CELLS cells.
- Each player keeps at most HIST live marks, stored in a per-player circular history FIFO. When a player places a mark while already holding HIST marks, that player's own oldest mark disappears in the same cycle.
- Adds move validation, optional turn enforcement, reject reporting and an "oldest mark" hint for display blinking. It sits between the input decoder and the win checker / display driver.

Parameters:
- CELLS, 9, number of board cells (3x3 default; 16 for 4x4).
- POS_W, 4, width of pos; must satisfy 2^POS_W >= CELLS.
- HIST, 3, maximum live marks per player; range 1..CELLS/2.
- ENFORCE_TURN, 1, 1 = strict alternation, A first; 0 = either player may move any cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- game_state  in  1  1 = game running; moves ignored (not rejected) when 0.
- clear  in  1  synchronous board clear; priority over moves.
- player_a_move  in  1  single-cycle move strobe for A.
- player_b_move  in  1  single-cycle move strobe for B.
- pos  in  POS_W  target cell, 0..CELLS-1.
- game_grid  out  2*CELLS  bits [CELLS-1:0] are A circles; bits [2*CELLS-1:CELLS] are B crosses.
- move_ack  out  1  one-cycle pulse when a move is accepted.
- move_reject  out  1  one-cycle pulse when a move is rejected.
- reject_code  out  2  1 = occupied, 2 = out of range, 3 = wrong turn or simultaneous; holds its value until the next strobe.
- a_count  out  $clog2(HIST+1)  number of live A marks.
- b_count  out  $clog2(HIST+1)  number of live B marks.
- oldest_valid  out  1  1 when the player to move holds HIST marks; that mark disappears on their next accepted move.
- oldest_pos  out  POS_W  cell of that mark.
- turn  out  1  0 = A to move, 1 = B to move.

Behaviour:
- Reset (async, reset = 0) clears every register and output: game_grid, counts, FIFOs, move_ack, move_reject, reject_code, oldest_valid, oldest_pos and turn are all 0.
- clear = 1 gives the same result synchronously on the next edge.
- All outputs are registered. A strobe at edge N produces its grid update, ack/reject, counts and turn at edge N+1.
- Per-player FIFO: HIST entries of POS_W bits, with a write pointer and a read pointer that each wrap modulo HIST, plus a count.
- Move evaluation applies only when game_state = 1. Checks are in priority order:
  - a and b strobes both high -> reject, code 3, no state change.
  - ENFORCE_TURN = 1 and the strobing player is not turn -> reject, code 3.
  - pos >= CELLS -> reject, code 2.
  - Cell occupied by either player -> reject, code 1. This includes the mover's own oldest mark.
  - Otherwise accept.
- Accept, count < HIST:
  - Set the player's grid bit at pos.
  - Push pos to the FIFO; count += 1.
- Accept, count == HIST:
  - Pop the oldest entry and clear its grid bit.
  - Set the grid bit at pos and push pos.
  - Count is unchanged. The clear and set happen in one edge; they are always different cells.
- Every accepted move toggles turn, including when ENFORCE_TURN = 0.
- oldest_valid and oldest_pos are derived from the registered state of the player indicated by turn: the FIFO read entry when that player's count == HIST, otherwise oldest_valid = 0 and oldest_pos = 0.
- A strobe with game_state = 0 produces neither ack nor reject.
- Reset asserted mid-move aborts immediately; no partial grid update survives.
- Opponent marks are never removed by a move.
- No win detection is done in this block.

Test Plan:
- Reset, then A pos = 4 -> next cycle game_grid = 18'h00010, a_count = 1, move_ack = 1, turn = 1.
- Alternate A: 0, 1, 2 with B: 3, 5, 6 -> grid A bits {0,1,2}, B bits {3,5,6}. After B's third move, turn = 0, oldest_valid = 1, oldest_pos = 0.
- Continue with A pos = 7 -> A bit 0 cleared and bit 7 set in the same cycle; a_count stays 3; oldest_pos then shows B's oldest, 3.
- Rejects:
  - A pos = 4 while B holds cell 4 -> move_reject, code 1, grid unchanged.
  - pos = 9 -> code 2.
  - B strobe on A's turn -> code 3.
  - Both strobes high -> code 3.
- Wrap-around: 10 accepted A/B move pairs -> each player's live cells are always exactly its last 3 positions; counts never exceed 3.
- Strobe with game_state = 0 -> no ack, no reject, no change. clear = 1 together with a strobe -> board empties, strobe ignored. reset low mid-game -> all outputs 0 asynchronously.
